// File: rtl/uni_shift_ctrl_pkg.sv
// uni_shift_pkg: shared control codes, FSM states and direction encoding for the serializer
package uni_shift_pkg;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_LEFT  = 2'b01;
    localparam logic [1:0] SR_RIGHT = 2'b10;
    localparam logic [1:0] SR_LOAD  = 2'b11;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/uni_shift_ctrl_core.sv
// uni_shift_core: N-bit universal shift register (hold/left/right/load) with zero fill
module uni_shift_core
    import uni_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   control,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out
);

    // Register update selected by the control code; vacated bits fill with zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            data_out <= '0;
        else
            case (control)
                SR_LEFT:  data_out <= {data_out[N-2:0], 1'b0};
                SR_RIGHT: data_out <= {1'b0, data_out[N-1:1]};
                SR_LOAD:  data_out <= data_in;
                default:  data_out <= data_out;
            endcase
    end

endmodule

// File: rtl/uni_shift_ctrl.sv
// uni_shift_ctrl: valid/ready word-to-serial controller driving a universal shift core
module uni_shift_ctrl
    import uni_shift_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_len,
    input  logic             flush,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             done,
    output logic             busy,
    output logic [1:0]       sr_control
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, eff_len;
    logic             dir, accept, xfer;
    logic [N-1:0]     core;

    uni_shift_core #(.N(N)) u_core (
        .clk      (clk),
        .reset    (reset),
        .control  (sr_control),
        .data_in  (in_data),
        .data_out (core)
    );

    assign eff_len = (in_len == '0 || in_len > CNT_W'(N)) ? CNT_W'(N) : in_len;
    assign accept  = state == IDLE && in_valid && !flush;
    assign xfer    = state == SHIFT && ser_ready && !flush;
    assign busy    = state != IDLE;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Bit counter and direction captured with each accepted word; flush abandons the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            dir <= DIR_MSB_FIRST;
        end else if (accept) begin
            cnt <= eff_len;
            dir <= in_dir;
        end else if (flush && state != IDLE) begin
            cnt <= '0;
        end else if (xfer && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Next state, handshake outputs and the control code for the shift core
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        ser_last   = 1'b0;
        done       = 1'b0;
        sr_control = SR_HOLD;
        case (state)
            IDLE: begin
                in_ready   = !flush;
                sr_control = accept ? SR_LOAD : SR_HOLD;
                state_nxt  = accept ? SHIFT : IDLE;
            end
            SHIFT: begin
                ser_valid  = 1'b1;
                ser_out    = (dir == DIR_MSB_FIRST) ? core[N-1] : core[0];
                ser_last   = cnt == CNT_W'(1);
                sr_control = !xfer ? SR_HOLD : (dir == DIR_LSB_FIRST) ? SR_RIGHT : SR_LEFT;
                state_nxt  = flush ? IDLE : (xfer && cnt == CNT_W'(1)) ? DONE : SHIFT;
            end
            DONE: begin
                done      = !flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uni_shift_ctrl.sv
// tb_uni_shift_ctrl: scenario tasks checking the serializer against a bit-order model
module tb_uni_shift_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [N-1:0]     in_data = '0;
    logic             in_dir = 1'b0;
    logic [CNT_W-1:0] in_len = '0;
    logic             flush = 1'b0;
    logic             ser_ready = 1'b0;
    logic             in_ready, ser_out, ser_valid, ser_last, done, busy;
    logic [1:0]       sr_control;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc_abs = 0;

    int rx_q[$];
    int last_idx, done_cnt, first_lat, first_abs, last_abs, done_abs, rdy_busy;
    bit timed_out;

    uni_shift_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dir     (in_dir),
        .in_len     (in_len),
        .flush      (flush),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_last   (ser_last),
        .done       (done),
        .busy       (busy),
        .sr_control (sr_control)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    function automatic int eff(input int l);
        return (l == 0 || l > N) ? N : l;
    endfunction

    function automatic int model_bit(input logic [N-1:0] w, input logic d, input int i);
        return d ? int'(w[i]) : int'(w[N-1-i]);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            total_cnt++;
            if ((sr_control == 2'b11 && !(in_valid && in_ready && !busy)) || (ser_valid && !busy) || (done && ser_valid))
                $display("FAIL invariant: sr_control=%b in_valid=%b in_ready=%b busy=%b ser_valid=%b done=%b; required load only on idle handshake, valid only while busy, no valid with done",
                         sr_control, in_valid, in_ready, busy, ser_valid, done);
            else
                pass_cnt++;
        end
    end

    task automatic run_word(input logic [N-1:0] w, input logic d, input logic [CNT_W-1:0] l, input int rmode, input bit hold_valid);
        int t;
        int c;
        rx_q.delete();
        last_idx = -1; done_cnt = 0; first_lat = -1; first_abs = -1; last_abs = -1; done_abs = -1; rdy_busy = 0; timed_out = 0;
        in_data = w; in_dir = d; in_len = l; in_valid = 1'b1;
        #1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #2;
            t++;
        end
        if (t >= 50) timed_out = 1;
        @(posedge clk); #1;
        if (!hold_valid) in_valid = 1'b0;
        for (c = 1; c < 100; c++) begin
            ser_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((c % 3) == 1) : 1'($urandom_range(0, 1));
            #1;
            if (in_ready) rdy_busy++;
            if (ser_valid && first_lat < 0) begin
                first_lat = c;
                first_abs = cyc_abs;
            end
            if (done) begin
                done_cnt++;
                done_abs = cyc_abs;
                break;
            end
            if (ser_valid && ser_ready) begin
                if (ser_last) begin
                    last_idx = rx_q.size();
                    last_abs = cyc_abs;
                end
                rx_q.push_back(int'(ser_out));
            end
            @(posedge clk); #1;
        end
        if (c >= 100) timed_out = 1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        total_cnt++; if (ser_valid !== 1'b0) $display("FAIL rst_ser_valid got %b exp 0", ser_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else pass_cnt++;
        total_cnt++; if (sr_control !== 2'b00) $display("FAIL rst_sr_control got %b exp 00", sr_control); else pass_cnt++;
        total_cnt++; if (ser_out !== 1'b0 || ser_last !== 1'b0 || done !== 1'b0) $display("FAIL rst_outs got out=%b last=%b done=%b exp 0 0 0", ser_out, ser_last, done); else pass_cnt++;
        #1 reset = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_msb_full();
        run_word(8'hA5, 1'b0, 4'd0, 0, 1'b0);
        total_cnt++; if (timed_out) $display("FAIL t1_timeout got 1 exp 0"); else pass_cnt++;
        total_cnt++; if (first_lat !== 1) $display("FAIL t1_first_latency got %0d exp 1", first_lat); else pass_cnt++;
        total_cnt++; if (rx_q.size() !== 8) $display("FAIL t1_count got %0d exp 8", rx_q.size()); else pass_cnt++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            total_cnt++; if (rx_q[i] !== model_bit(8'hA5, 1'b0, i)) $display("FAIL t1_bit%0d got %0d exp %0d", i, rx_q[i], model_bit(8'hA5, 1'b0, i)); else pass_cnt++;
        end
        total_cnt++; if (last_idx !== 7) $display("FAIL t1_last_idx got %0d exp 7", last_idx); else pass_cnt++;
        total_cnt++; if (done_cnt !== 1 || done_abs !== last_abs + 1) $display("FAIL t1_done got cnt=%0d at %0d exp 1 at %0d", done_cnt, done_abs, last_abs + 1); else pass_cnt++;
        @(posedge clk); #2;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL t1_in_ready_after got %b exp 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_lsb_len3();
        int extra = 0;
        run_word(8'hA5, 1'b1, 4'd3, 0, 1'b0);
        total_cnt++; if (timed_out) $display("FAIL t2_timeout got 1 exp 0"); else pass_cnt++;
        total_cnt++; if (rx_q.size() !== 3) $display("FAIL t2_count got %0d exp 3", rx_q.size()); else pass_cnt++;
        for (int i = 0; i < rx_q.size() && i < 3; i++) begin
            total_cnt++; if (rx_q[i] !== model_bit(8'hA5, 1'b1, i)) $display("FAIL t2_bit%0d got %0d exp %0d", i, rx_q[i], model_bit(8'hA5, 1'b1, i)); else pass_cnt++;
        end
        total_cnt++; if (last_idx !== 2) $display("FAIL t2_last_idx got %0d exp 2", last_idx); else pass_cnt++;
        repeat (4) begin
            @(posedge clk); #2;
            if (done || ser_valid) extra++;
        end
        total_cnt++; if (done_cnt + extra !== 1) $display("FAIL t2_done_once got %0d exp 1", done_cnt + extra); else pass_cnt++;
    endtask

    task automatic test_stall();
        int t = 0;
        bit prev_stall = 0;
        bit got_done = 0;
        logic prev_bit = 1'b0;
        rx_q.delete();
        in_data = 8'hF0; in_dir = 1'b0; in_len = 4'd0; in_valid = 1'b1; ser_ready = 1'b0;
        #1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #2;
            t++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c < 60 && !got_done; c++) begin
            ser_ready = (c % 3) == 1;
            #1;
            if (prev_stall) begin
                total_cnt++; if (ser_out !== prev_bit || !ser_valid) $display("FAIL t3_hold_c%0d got out=%b valid=%b exp out=%b valid=1", c, ser_out, ser_valid, prev_bit); else pass_cnt++;
            end
            if (ser_valid && !ser_ready) begin
                total_cnt++; if (sr_control !== 2'b00) $display("FAIL t3_stall_ctrl_c%0d got %b exp 00", c, sr_control); else pass_cnt++;
            end
            prev_stall = ser_valid && !ser_ready;
            prev_bit = ser_out;
            if (ser_valid && ser_ready) rx_q.push_back(int'(ser_out));
            if (done) got_done = 1;
            @(posedge clk); #1;
        end
        total_cnt++; if (!got_done) $display("FAIL t3_done got 0 exp 1"); else pass_cnt++;
        total_cnt++; if (rx_q.size() !== 8) $display("FAIL t3_count got %0d exp 8", rx_q.size()); else pass_cnt++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            total_cnt++; if (rx_q[i] !== model_bit(8'hF0, 1'b0, i)) $display("FAIL t3_bit%0d got %0d exp %0d", i, rx_q[i], model_bit(8'hF0, 1'b0, i)); else pass_cnt++;
        end
        #1;
    endtask

    task automatic test_flush();
        logic [N-1:0] w;
        int t = 0;
        w = N'($urandom);
        flush = 1'b1; in_valid = 1'b1; in_data = w; in_dir = 1'b0; in_len = 4'd0;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL t4_idle_flush_ready got %b exp 0", in_ready); else pass_cnt++;
        @(posedge clk); #2;
        total_cnt++; if (busy !== 1'b0) $display("FAIL t4_idle_flush_busy got %b exp 0", busy); else pass_cnt++;
        flush = 1'b0;
        #1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #2;
            t++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; ser_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total_cnt++; if (ser_valid !== 1'b1 || ser_out !== 1'(model_bit(w, 1'b0, c))) $display("FAIL t4_pre_bit%0d got valid=%b out=%b exp 1 %0d", c, ser_valid, ser_out, model_bit(w, 1'b0, c)); else pass_cnt++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        total_cnt++; if (sr_control !== 2'b00) $display("FAIL t4_flush_ctrl got %b exp 00", sr_control); else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || ser_valid !== 1'b0 || done !== 1'b0) $display("FAIL t4_after_flush got busy=%b valid=%b done=%b exp 0 0 0", busy, ser_valid, done); else pass_cnt++;
        run_word(8'h81, 1'b0, 4'd0, 0, 1'b0);
        total_cnt++; if (rx_q.size() !== 8 || done_cnt !== 1 || first_lat !== 1) $display("FAIL t4_next_word got count=%0d done=%0d lat=%0d exp 8 1 1", rx_q.size(), done_cnt, first_lat); else pass_cnt++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            total_cnt++; if (rx_q[i] !== model_bit(8'h81, 1'b0, i)) $display("FAIL t4_bit%0d got %0d exp %0d", i, rx_q[i], model_bit(8'h81, 1'b0, i)); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        int t = 0;
        in_data = N'($urandom) | 8'h01; in_dir = 1'b1; in_len = 4'd0; in_valid = 1'b1; ser_ready = 1'b1;
        #1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #2;
            t++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        total_cnt++; if (ser_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t5_drop got valid=%b busy=%b exp 0 0", ser_valid, busy); else pass_cnt++;
        total_cnt++; if (dut.u_core.data_out !== 8'h00 || ser_out !== 1'b0) $display("FAIL t5_core got %h out=%b exp 00 0", dut.u_core.data_out, ser_out); else pass_cnt++;
        @(posedge clk); #2;
        total_cnt++; if (done !== 1'b0 || in_ready !== 1'b1) $display("FAIL t5_in_reset got done=%b ready=%b exp 0 1", done, in_ready); else pass_cnt++;
        #1 reset = 1'b1;
        @(posedge clk); #2;
        total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) $display("FAIL t5_release got ready=%b busy=%b done=%b exp 1 0 0", in_ready, busy, done); else pass_cnt++;
        run_word(8'h3C, 1'b0, 4'd0, 0, 1'b0);
        total_cnt++; if (rx_q.size() !== 8 || done_cnt !== 1 || first_lat !== 1) $display("FAIL t5_next_word got count=%0d done=%0d lat=%0d exp 8 1 1", rx_q.size(), done_cnt, first_lat); else pass_cnt++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            total_cnt++; if (rx_q[i] !== model_bit(8'h3C, 1'b0, i)) $display("FAIL t5_bit%0d got %0d exp %0d", i, rx_q[i], model_bit(8'h3C, 1'b0, i)); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] w1, w2;
        logic d;
        int last1;
        w1 = N'($urandom); w2 = N'($urandom); d = 1'($urandom);
        run_word(w1, d, 4'd9, 0, 1'b1);
        last1 = last_abs;
        total_cnt++; if (rx_q.size() !== 8 || rdy_busy !== 0 || done_cnt !== 1) $display("FAIL t6_word1 got count=%0d ready_cycles=%0d done=%0d exp 8 0 1", rx_q.size(), rdy_busy, done_cnt); else pass_cnt++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            total_cnt++; if (rx_q[i] !== model_bit(w1, d, i)) $display("FAIL t6_w1_bit%0d got %0d exp %0d", i, rx_q[i], model_bit(w1, d, i)); else pass_cnt++;
        end
        run_word(w2, d, 4'd9, 0, 1'b1);
        in_valid = 1'b0;
        total_cnt++; if (first_abs - last1 !== 3) $display("FAIL t6_gap got %0d exp 3", first_abs - last1); else pass_cnt++;
        total_cnt++; if (rx_q.size() !== 8 || rdy_busy !== 0 || timed_out) $display("FAIL t6_word2 got count=%0d ready_cycles=%0d timeout=%0d exp 8 0 0", rx_q.size(), rdy_busy, timed_out); else pass_cnt++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            total_cnt++; if (rx_q[i] !== model_bit(w2, d, i)) $display("FAIL t6_w2_bit%0d got %0d exp %0d", i, rx_q[i], model_bit(w2, d, i)); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] w;
        logic d;
        logic [CNT_W-1:0] l;
        int e;
        for (int k = 0; k < 8; k++) begin
            w = N'($urandom); d = 1'($urandom); l = CNT_W'($urandom_range(0, 15));
            e = eff(int'(l));
            run_word(w, d, l, 2, 1'b0);
            total_cnt++; if (timed_out || done_cnt !== 1) $display("FAIL rnd%0d_done got timeout=%0d done=%0d exp 0 1", k, timed_out, done_cnt); else pass_cnt++;
            total_cnt++; if (rx_q.size() !== e || last_idx !== e - 1) $display("FAIL rnd%0d_len got count=%0d last=%0d exp %0d %0d", k, rx_q.size(), last_idx, e, e - 1); else pass_cnt++;
            for (int i = 0; i < rx_q.size() && i < e; i++) begin
                total_cnt++; if (rx_q[i] !== model_bit(w, d, i)) $display("FAIL rnd%0d_bit%0d got %0d exp %0d", k, i, rx_q[i], model_bit(w, d, i)); else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_full();
        test_lsb_len3();
        test_stall();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        @(posedge clk); #2;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uni_shift_ctrl.md
Name: uni_shift_ctrl

Overview:
Parallel-to-serial controller built around a universal shift register datapath.
- Accepts N-bit words on a valid/ready interface.
- Sequences the register through load / shift / hold control codes.
- Streams a programmable number of bits out serially, either MSB-first or LSB-first, with downstream backpressure.
- Sits between a word-wide producer and a bit-serial link (SPI-style transmit, test-pattern shifter).

Parameters:
N, 8, shift register width and maximum bits per word
CNT_W, $clog2(N+1), width of the length field and bit counter

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  producer presents a word
in_ready  output  1  controller can accept a word
in_data  input  N  parallel word to serialize
in_dir  input  1  0 = shift left, MSB-first; 1 = shift right, LSB-first; sampled with the word
in_len  input  CNT_W  number of bits to send; 0 or >N means N; sampled with the word
flush  input  1  synchronous abort of the current word
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out is valid
ser_ready  input  1  consumer accepts the bit
ser_last  output  1  current bit is the final bit of the word
done  output  1  one-cycle pulse after the final bit is accepted
busy  output  1  word in progress (state != IDLE)
sr_control  output  2  control code driven into the shift core: 00 hold, 01 left, 10 right, 11 load

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values, applied immediately on assertion, including mid-word:
  - state IDLE, shift core 0, bit counter 0, dir 0, done 0.
  - Combinational outputs then read: ser_valid 0, ser_last 0, busy 0, ser_out 0, sr_control 00, in_ready 1.
  - A word in flight at reset is discarded silently, with no done pulse.
- FSM state IDLE:
  - in_ready = ~flush.
  - On in_valid & in_ready: sr_control = 11, so the core loads in_data on this edge.
  - Same edge: capture in_dir, set cnt = effective length, go to SHIFT.
  - Otherwise sr_control = 00.
- FSM state SHIFT:
  - ser_valid = 1; in_ready = 0.
  - ser_out = core[N-1] when dir = 0, core[0] when dir = 1.
  - ser_last = (cnt == 1).
  - On ser_valid & ser_ready: sr_control = 01 (dir 0) or 10 (dir 1); cnt decrements.
  - If that accepted bit was last, go to DONE.
  - When ser_ready = 0: sr_control = 00; core, ser_out and cnt stay stable (AXI-style hold; ser_valid never drops without a transfer).
- FSM state DONE:
  - One cycle; done = 1; sr_control = 00; returns to IDLE.
  - Words are accepted only in IDLE, so throughput is len + 2 cycles per word.
- Latency: handshake at edge k gives first bit valid in cycle k+1. Final bit accepted at edge m gives done high in cycle m+1 and in_ready high in cycle m+2.
- Shift fill: vacated bits are 0. The core is not cleared after a word.
- flush:
  - In SHIFT or DONE: next state IDLE, cnt cleared, no done pulse, sr_control = 00. Flush overrides a simultaneous bit handshake; that bit counts as not transferred.
  - In IDLE: in_ready forced 0, so no load.
- Width rules:
  - Effective length = N when in_len == 0 or in_len > N, otherwise in_len.
  - cnt is CNT_W bits and never underflows.
- Assertions for the bench:
  - sr_control == 11 only in IDLE with a handshake.
  - ser_valid implies state SHIFT.
  - done implies ser_valid == 0.

Decomposition:
- Package uni_shift_pkg holds:
  - Control code constants: SR_HOLD = 2'b00, SR_LEFT = 2'b01, SR_RIGHT = 2'b10, SR_LOAD = 2'b11.
  - FSM state encoding: IDLE, SHIFT, DONE.
  - DIR_MSB_FIRST = 0, DIR_LSB_FIRST = 1.
- One sub-module, uni_shift_core:
  - N-bit universal shift register with the package control encoding, zero fill, and asynchronous active-low reset.
  - Ports: clk, reset, control, data_in, data_out.
- The controller instantiates one core and drives sr_control into it.

Test Plan:
1. Reset release, in_data = 8'hA5, dir 0, len 0, ser_ready held 1 -> bits 1,0,1,0,0,1,0,1 on consecutive cycles starting the cycle after the handshake; ser_last on the 8th bit; done on the next cycle; in_ready 1 one cycle later.
2. in_data = 8'hA5, dir 1, len 3 -> bits 1,0,1 (LSB-first); ser_last on the 3rd; exactly 3 transfers; done once.
3. dir 0, 8'hF0, ser_ready toggling 1,0,0,1,... -> ser_out and sr_control = 00 stable during the stalls; output sequence 1,1,1,1,0,0,0,0 with nothing lost or duplicated.
4. Flush after 2 of 8 bits accepted, asserted together with ser_ready -> next cycle IDLE, no done, third bit never counted; a following word 8'h81 serializes cleanly from its MSB.
5. Reset asserted asynchronously mid-word (between clock edges) -> ser_valid and busy drop immediately, core reads 0; after release the bench sees in_ready = 1 and the next word 8'h3C streams normally.
6. len = 9 (greater than N) and back-to-back in_valid held high -> each word sends 8 bits; in_ready is low from acceptance through DONE; gap between ser_last and the next first bit is exactly 2 cycles.
